// File: rtl/light_package.sv
// Shared types for the N-phase traffic light controller: light colours,
// the FSM state encoding and a counter-width helper.
package light_package;

   // Per-phase lamp colour driven on the light output.
   typedef enum logic [1:0] {
      RED    = 2'd0,
      YELLOW = 2'd1,
      GREEN  = 2'd2
   } colors;

   // Controller state, kept as plain constants so older tools can read them.
   typedef logic [1:0] tlc_nphase_state_t;

   localparam tlc_nphase_state_t S_ALLRED = 2'd0;
   localparam tlc_nphase_state_t S_GREEN  = 2'd1;
   localparam tlc_nphase_state_t S_YELLOW = 2'd2;

   // Bits needed to hold values 0..maxval; never less than one bit.
   function automatic int cnt_w(input int maxval);
      return (maxval < 1) ? 1 : $clog2(maxval + 1);
   endfunction

endpackage

// File: rtl/tlc_rr_arbiter.sv
// Combinational round-robin phase picker: the first set request bit after
// i_last (wrapping), with i_last itself tried last.
module tlc_rr_arbiter
   import light_package::*;
#(
   parameter int NUM_PHASES = 5
) (
   input  logic [NUM_PHASES-1:0]         i_req,
   input  logic [$clog2(NUM_PHASES)-1:0] i_last,
   output logic [$clog2(NUM_PHASES)-1:0] o_grant,
   output logic                          o_grant_valid
);

   localparam int PW = $clog2(NUM_PHASES);

   logic [PW:0] w_sum;
   logic [PW:0] w_idx;

   // Walk from the farthest candidate to the nearest so the nearest set bit wins.
   always_comb begin
      o_grant       = i_last;
      o_grant_valid = 1'b0;
      w_sum         = '0;
      w_idx         = '0;
      for (int k = NUM_PHASES; k >= 1; k--) begin
         w_sum = {1'b0, i_last} + (PW+1)'(k);
         w_idx = (w_sum >= (PW+1)'(NUM_PHASES)) ? (w_sum - (PW+1)'(NUM_PHASES)) : w_sum;
         if (i_req[w_idx[PW-1:0]]) begin
            o_grant       = w_idx[PW-1:0];
            o_grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tlc_nphase.sv
// N-phase actuated traffic light controller (Moore outputs).
// Optional emergency preemption is built only when TLC_PREEMPT_EN is defined.
// Handshake note: there is no valid/ready traffic here; sensor and preempt are
// level inputs sampled on every rising edge.
module tlc_nphase
   import light_package::*;
#(
   parameter int NUM_PHASES  = 5,
   parameter int GAP_TIME    = 5,
   parameter int MAX_GREEN   = 10,
   parameter int YELLOW_TIME = 2,
   parameter int ALLRED_TIME = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_PHASES-1:0]         sensor,
   input  logic                          preempt,
   input  logic [$clog2(NUM_PHASES)-1:0] preempt_phase,
   output colors                         light [NUM_PHASES],
   output logic [$clog2(NUM_PHASES)-1:0] active_phase,
   output tlc_nphase_state_t             o_dbg_state
);

   localparam int PW   = $clog2(NUM_PHASES);
   localparam int MAXT = (YELLOW_TIME > ALLRED_TIME) ? YELLOW_TIME : ALLRED_TIME;
   localparam int TW   = cnt_w(MAXT);
   localparam int GW   = cnt_w(GAP_TIME);
   localparam int MW   = cnt_w(MAX_GREEN);

   tlc_nphase_state_t r_state;
   logic [PW-1:0]     r_active;
   logic [TW-1:0]     r_timer;
   logic [GW-1:0]     r_gap;
   logic [MW-1:0]     r_max;

   logic [NUM_PHASES-1:0] w_other_req;
   logic                  w_own;
   logic                  w_other;
   logic [GW-1:0]         w_gap_nxt;
   logic [MW-1:0]         w_max_nxt;
   logic                  w_limit;
   logic [PW-1:0]         w_grant;
   logic                  w_grant_valid;
   logic                  w_start_ok;
   logic [PW-1:0]         w_start_phase;
   logic                  w_pre_force;
   logic                  w_pre_hold;

   tlc_rr_arbiter #(
      .NUM_PHASES (NUM_PHASES)
   ) u_arb (
      .i_req         (sensor),
      .i_last        (r_active),
      .o_grant       (w_grant),
      .o_grant_valid (w_grant_valid)
   );

`ifdef TLC_PREEMPT_EN
   logic w_pre_req;
   // Out-of-range preempt_phase values are treated as no request.
   assign w_pre_req     = preempt && ({1'b0, preempt_phase} < (PW+1)'(NUM_PHASES));
   assign w_pre_force   = w_pre_req && (preempt_phase != r_active);
   assign w_pre_hold    = w_pre_req && (preempt_phase == r_active);
   assign w_start_ok    = w_pre_req || w_grant_valid;
   assign w_start_phase = w_pre_req ? preempt_phase : w_grant;
`else
   logic w_unused_preempt;
   assign w_unused_preempt = ^{preempt, preempt_phase};
   assign w_pre_force      = 1'b0;
   assign w_pre_hold       = 1'b0;
   assign w_start_ok       = w_grant_valid;
   assign w_start_phase    = w_grant;
`endif

   // Demand from every phase except the one currently served.
   always_comb begin
      w_other_req           = sensor;
      w_other_req[r_active] = 1'b0;
   end

   assign w_own     = sensor[r_active];
   assign w_other   = |w_other_req;
   assign w_gap_nxt = w_own ? '0 :
                      ((r_gap == GW'(GAP_TIME)) ? r_gap : r_gap + GW'(1));
   assign w_max_nxt = (w_other && (r_max != MW'(MAX_GREEN))) ? r_max + MW'(1) : r_max;
   assign w_limit   = (w_gap_nxt == GW'(GAP_TIME)) || (w_max_nxt == MW'(MAX_GREEN));

   // Phase sequencing: ALLRED -> GREEN -> YELLOW -> ALLRED, reset wins over all.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_ALLRED;
         r_timer  <= TW'(ALLRED_TIME);
         r_active <= PW'(NUM_PHASES - 1);
         r_gap    <= '0;
         r_max    <= '0;
      end else begin
         case (r_state)
            S_ALLRED: begin
               // Timer parks at 1 while dwelling so a later request exits at once.
               if (r_timer > TW'(1)) begin
                  r_timer <= r_timer - TW'(1);
               end else if (w_start_ok) begin
                  r_state  <= S_GREEN;
                  r_active <= w_start_phase;
                  r_gap    <= '0;
                  r_max    <= '0;
               end
            end
            S_GREEN: begin
               r_gap <= w_gap_nxt;
               r_max <= w_max_nxt;
               if (w_pre_force || (!w_pre_hold && w_other && w_limit)) begin
                  r_state <= S_YELLOW;
                  r_timer <= TW'(YELLOW_TIME);
               end
            end
            S_YELLOW: begin
               if (r_timer > TW'(1)) begin
                  r_timer <= r_timer - TW'(1);
               end else begin
                  r_state <= S_ALLRED;
                  r_timer <= TW'(ALLRED_TIME);
               end
            end
            default: begin
               r_state <= S_ALLRED;
               r_timer <= TW'(ALLRED_TIME);
            end
         endcase
      end
   end

   // Lamp decode from registered state: only the active phase may show colour.
   always_comb begin
      for (int i = 0; i < NUM_PHASES; i++) begin
         light[i] = RED;
         if (PW'(i) == r_active) begin
            if (r_state == S_GREEN) begin
               light[i] = GREEN;
            end else if (r_state == S_YELLOW) begin
               light[i] = YELLOW;
            end
         end
      end
   end

   assign active_phase = r_active;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_tlc_nphase.sv
// Self-checking bench for tlc_nphase (default parameters). Expected per-cycle
// observations {state, active_phase, lights} are queued as stimulus is applied
// and compared cycle by cycle. Define TLC_PREEMPT_EN to exercise preemption.
module tb_tlc_nphase;
   import light_package::*;

   localparam int N  = 5;
   localparam int PW = 3;
   localparam int W  = 2 + PW + 2*N;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      sensor;
   logic              preempt;
   logic [PW-1:0]     preempt_phase;
   colors             light [N];
   logic [PW-1:0]     active_phase;
   tlc_nphase_state_t dbg_state;

   logic [W-1:0] exp_q[$];
   int           n_total = 0;
   int           n_bad   = 0;

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got=no_finish exp=finish_before_100000");
      $fatal(1, "watchdog expired");
   end

   tlc_nphase #(
      .NUM_PHASES  (N),
      .GAP_TIME    (5),
      .MAX_GREEN   (10),
      .YELLOW_TIME (2),
      .ALLRED_TIME (1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .sensor        (sensor),
      .preempt       (preempt),
      .preempt_phase (preempt_phase),
      .light         (light),
      .active_phase  (active_phase),
      .o_dbg_state   (dbg_state)
   );

   // Expected observation for a state and phase, derived from the lamp rules.
   function automatic logic [W-1:0] mk(input tlc_nphase_state_t st, input int ph);
      logic [W-1:0] w;
      colors        c;
      c = (st == S_GREEN) ? GREEN : ((st == S_YELLOW) ? YELLOW : RED);
      w = '0;
      w[W-1 -: 2]   = st;
      w[2*N +: PW]  = PW'(ph);
      for (int i = 0; i < N; i++) begin
         w[2*i +: 2] = (i == ph) ? c : RED;
      end
      return w;
   endfunction

   function automatic logic [W-1:0] observe();
      logic [W-1:0] w;
      w = '0;
      w[W-1 -: 2]  = dbg_state;
      w[2*N +: PW] = active_phase;
      for (int i = 0; i < N; i++) begin
         w[2*i +: 2] = light[i];
      end
      return w;
   endfunction

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h (state|phase|lights)", tag, got, exp);
      end
   endtask

   // Step to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input tlc_nphase_state_t st, input int ph, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(mk(st, ph));
      end
   endtask

   // One expected entry is consumed per clock cycle.
   task automatic drain(input string tag);
      logic [W-1:0] e;
      while (exp_q.size() > 0) begin
         tick();
         e = exp_q.pop_front();
         check_eq(tag, observe(), e);
      end
   endtask

   initial begin
      logic found;
      reset         = 1'b1;
      sensor        = 5'b00100;
      preempt       = 1'b0;
      preempt_phase = '0;
      tick();

      // Reset state and first grant
      push(S_ALLRED, 4, 1); drain("rst");
      reset = 1'b0;
      push(S_GREEN, 2, 1); drain("first_grant");

      // Gap-out: phase 2 loses own demand while phase 0 waits
      sensor = 5'b00001;
      push(S_GREEN, 2, 4); push(S_YELLOW, 2, 2); push(S_ALLRED, 2, 1); push(S_GREEN, 0, 1);
      drain("gap_end");

      // Max-out: phase 0 keeps demand while phase 1 competes
      sensor = 5'b00011;
      push(S_GREEN, 0, 9); push(S_YELLOW, 0, 2); push(S_ALLRED, 0, 1); push(S_GREEN, 1, 1);
      drain("max_end");

      // Reset on the second yellow cycle aborts straight to all red
      sensor = 5'b00001;
      push(S_GREEN, 1, 4); push(S_YELLOW, 1, 2); drain("pre_abort");
      reset = 1'b1;
      push(S_ALLRED, 4, 1); drain("yel_abort");
      reset = 1'b0;
      push(S_GREEN, 0, 1); drain("post_abort");

      // Round-robin wrap from last phase 4
      reset  = 1'b1;
      sensor = 5'b10001;
      push(S_ALLRED, 4, 1); drain("rst2");
      reset = 1'b0;
      push(S_GREEN, 0, 1); drain("rr_first");
      push(S_GREEN, 0, 9); push(S_YELLOW, 0, 2); push(S_ALLRED, 0, 1); push(S_GREEN, 4, 1);
      drain("rr_wrap");
      push(S_GREEN, 4, 9); push(S_YELLOW, 4, 2); push(S_ALLRED, 4, 1); push(S_GREEN, 0, 1);
      drain("rr_back");

      // No competing demand: green holds well past both limits
      sensor = 5'b00000;
      push(S_GREEN, 0, 15); drain("hold_idle");
      // Saturated gap counter ends green on the first competing edge
      sensor = 5'b01000;
      push(S_YELLOW, 0, 2); push(S_ALLRED, 0, 1); push(S_GREEN, 3, 1); drain("gap_sat");

      // Demand vanishing during yellow neither shortens it nor exits all red
      sensor = 5'b00001;
      push(S_GREEN, 3, 4); push(S_YELLOW, 3, 1); drain("g3_gap");
      sensor = 5'b00000;
      push(S_YELLOW, 3, 1); push(S_ALLRED, 3, 5); drain("dwell");
      sensor = 5'b00100;
      push(S_GREEN, 2, 1); drain("dwell_exit");

`ifdef TLC_PREEMPT_EN
      sensor = 5'b00010;
      push(S_GREEN, 2, 4); push(S_YELLOW, 2, 2); push(S_ALLRED, 2, 1); push(S_GREEN, 1, 1);
      drain("to_g1");
      preempt       = 1'b1;
      preempt_phase = 3'd3;
      push(S_YELLOW, 1, 2); push(S_ALLRED, 1, 1); push(S_GREEN, 3, 6); drain("pre_go");
      preempt = 1'b0;
      sensor  = 5'b10010;
      found   = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         tick();
         if (dbg_state == S_GREEN && active_phase != 3'd3) found = 1'b1;
      end
      check_eq("pre_resume_to", W'(found), W'(1));
      push(S_GREEN, 4, 1);
      check_eq("pre_resume", observe(), exp_q.pop_front());
`else
      found         = 1'b0;
      preempt       = 1'b1;
      preempt_phase = 3'd3;
      push(S_GREEN, 2, 6); drain("pre_ignored");
      preempt = 1'b0;
      sensor  = 5'b00010;
      push(S_GREEN, 2, 4); push(S_YELLOW, 2, 2); push(S_ALLRED, 2, 1); push(S_GREEN, 1, 1);
      drain("after_ignored");
      check_eq("found_unused", W'(found), W'(0));
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/tlc_nphase.md
TLC_NPHASE -- requirements
Module: tlc_nphase

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 5: number of mutually exclusive signal phases, legal range 2..16.
REQ-002 SHALL have parameter GAP_TIME, default 5: cycles of own-demand absence before green may end.
REQ-003 SHALL have parameter MAX_GREEN, default 10: cycles of competing demand before green must end.
REQ-004 SHALL have parameter YELLOW_TIME, default 2: yellow duration in cycles, minimum 1.
REQ-005 SHALL have parameter ALLRED_TIME, default 1: all-red duration in cycles, minimum 1.
REQ-006 SHALL have port clk, input, 1 bit: single clock, all logic on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port sensor, input, NUM_PHASES bits: bit i = demand for phase i.
REQ-009 SHALL have port preempt, input, 1 bit: emergency preemption request.
REQ-010 SHALL have port preempt_phase, input, $clog2(NUM_PHASES) bits: phase index to serve on preemption.
REQ-011 SHALL have port light, output, NUM_PHASES x colors: per-phase red/yellow/green.
REQ-012 SHALL have port active_phase, output, $clog2(NUM_PHASES) bits: phase currently green or yellow, else last served phase.

Function
REQ-013 SHALL implement the FSM states ALLRED, GREEN and YELLOW; light is registered-state decoded (Moore).
REQ-014 In ALLRED, all lights SHALL be red; in GREEN or YELLOW, only light[active_phase] SHALL be green or yellow, and all others red.
REQ-015 ALLRED SHALL last exactly ALLRED_TIME cycles, then dwell (all red) until any sensor bit is 1.
REQ-016 On leaving ALLRED, the next phase SHALL be the first set sensor bit searching active_phase+1 upward, wrapping modulo NUM_PHASES, with active_phase itself checked last.
REQ-017 In GREEN, gap_cnt SHALL reset to 0 when sensor[active_phase]=1, else increment, saturating at GAP_TIME.
REQ-018 In GREEN, max_cnt SHALL increment while any other sensor bit is 1, else hold, saturating at MAX_GREEN; both counters clear on entering GREEN.
REQ-019 GREEN SHALL go to YELLOW when another sensor bit is 1 AND (gap_cnt or max_cnt reaches its parameter on this edge); with no competing demand it SHALL hold green indefinitely.
REQ-020 YELLOW SHALL last exactly YELLOW_TIME cycles, then go to ALLRED.
REQ-021 Counters SHALL be sized from the parameters and never wrap.
REQ-022 Sensor changes during YELLOW or ALLRED timing SHALL NOT shorten either interval.

Reset
REQ-023 Reset SHALL force ALLRED with the timer loaded, active_phase=NUM_PHASES-1 (phase 0 highest priority first), counters 0, and all lights red on the next cycle.
REQ-024 Reset asserted mid-GREEN or mid-YELLOW SHALL abort immediately with no yellow; reset has priority over every input.

Configuration
REQ-025 With macro TLC_PREEMPT_EN defined: preempt=1 during GREEN of a phase other than preempt_phase SHALL force YELLOW on the next edge, ignoring counters.
REQ-026 With TLC_PREEMPT_EN: the ALLRED exit SHALL select preempt_phase regardless of sensor, and GREEN SHALL hold while preempt=1; normal round-robin resumes from preempt_phase after release.
REQ-027 With TLC_PREEMPT_EN: preempt rising during YELLOW or ALLRED SHALL NOT shorten those intervals.
REQ-028 Without TLC_PREEMPT_EN, preempt and preempt_phase SHALL remain as ports but be ignored, and no preemption logic is synthesised.

Structure
REQ-029 The colors enum (red, yellow, green) and the FSM state typedef tlc_nphase_state_t SHALL live in light_package.
REQ-030 The round-robin next-phase search SHALL be a sub-module tlc_rr_arbiter, parameterised by NUM_PHASES, combinational, taking request vector and last index, returning grant index and grant_valid.

Verification
REQ-031 Reset, sensor=5'b00100 -> all red for 1 cycle, then light[2]=green and active_phase=2.
REQ-032 Phase 2 green, sensor=5'b00001 held -> green 5 cycles, yellow 2, all-red 1, then phase 0 green.
REQ-033 Phase 0 green, sensor=5'b00011 held -> green ends after max_cnt reaches 10, followed by yellow 2 and all-red 1, then phase 1 green.
REQ-034 sensor=5'b10001 with last phase 4 -> phase 0 granted; repeat after phase 0 serves -> phase 4 granted (wrap).
REQ-035 TLC_PREEMPT_EN defined, phase 1 green, preempt=1 with preempt_phase=3 -> yellow next cycle, 2 yellow, 1 all-red, phase 3 green held until preempt=0.
REQ-036 Reset pulsed on the 2nd cycle of yellow -> next cycle all red, active_phase=NUM_PHASES-1, no residual yellow.
